// File: rtl/glb_cfg_axil_bridge.sv
// AXI-lite slave to global cfg-chain bridge: one outstanding transaction,
// tile-range decode, one-cycle cfg strobes and bounded read-data wait.
module glb_cfg_axil_bridge #(
  parameter int unsigned AXI_ADDR_WIDTH      = 12,
  parameter int unsigned AXI_DATA_WIDTH      = 32,
  parameter int unsigned AXI_BYTE_OFFSET     = 2,
  parameter int unsigned REG_ADDR_WIDTH      = 6,
  parameter int unsigned TILE_SEL_ADDR_WIDTH = 4,
  parameter int unsigned NUM_TILES           = 12,
  parameter int unsigned RD_TIMEOUT          = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  // AXI-lite write address / data / response
  input  logic [AXI_ADDR_WIDTH-1:0] awaddr,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [AXI_DATA_WIDTH-1:0] wdata,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  // AXI-lite read
  input  logic [AXI_ADDR_WIDTH-1:0] araddr,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [AXI_DATA_WIDTH-1:0] rdata,
  output logic [1:0]                rresp,
  output logic                      rvalid,
  input  logic                      rready,
  // cfg chain
  output logic                      cfg_wr_en,
  output logic                      cfg_wr_clk_en,
  output logic [AXI_ADDR_WIDTH-1:0] cfg_wr_addr,
  output logic [AXI_DATA_WIDTH-1:0] cfg_wr_data,
  output logic                      cfg_rd_en,
  output logic                      cfg_rd_clk_en,
  output logic [AXI_ADDR_WIDTH-1:0] cfg_rd_addr,
  input  logic [AXI_DATA_WIDTH-1:0] cfg_rd_data,
  input  logic                      cfg_rd_data_valid
);

  localparam int unsigned TILE_LSB = REG_ADDR_WIDTH + AXI_BYTE_OFFSET;
  localparam int unsigned CNT_W    = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT + 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ISSUE = 3'd1,
    WR_RESP  = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4,
    RD_RESP  = 3'd5
  } state_e;

  state_e                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                bresp_q, bresp_d;
  logic [1:0]                rresp_q, rresp_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      wr_accept_c;
  logic                      rd_accept_c;

  // Tile field lies directly above the per-tile register index.
  function automatic logic tile_ok(input logic [AXI_ADDR_WIDTH-1:0] a);
    return 32'(a[TILE_LSB +: TILE_SEL_ADDR_WIDTH]) < 32'(NUM_TILES);
  endfunction

  // Writes take priority; AW and W are only ever taken together.
  assign wr_accept_c = (state_q == IDLE) && !reset && awvalid && wvalid;
  assign rd_accept_c = (state_q == IDLE) && !reset && arvalid && !(awvalid && wvalid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      bresp_q <= RESP_OKAY;
      rresp_q <= RESP_OKAY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      bresp_q <= bresp_d;
      rresp_q <= rresp_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    bresp_d = bresp_q;
    rresp_d = rresp_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (wr_accept_c) begin
          addr_d  = awaddr;
          wdata_d = wdata;
          if (tile_ok(awaddr)) begin
            state_d = WR_ISSUE;
          end else begin
            bresp_d = RESP_DECERR;
            state_d = WR_RESP;
          end
        end else if (rd_accept_c) begin
          addr_d = araddr;
          if (tile_ok(araddr)) begin
            state_d = RD_ISSUE;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_DECERR;
            state_d = RD_RESP;
          end
        end
      end
      WR_ISSUE: begin
        bresp_d = RESP_OKAY;
        state_d = WR_RESP;
      end
      WR_RESP: begin
        if (bready) state_d = IDLE;
      end
      RD_ISSUE: begin
        cnt_d   = '0;
        state_d = RD_WAIT;
      end
      // Wait is bounded: RD_TIMEOUT cycles in this state at most.
      RD_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cfg_rd_data_valid) begin
          rdata_d = cfg_rd_data;
          rresp_d = RESP_OKAY;
          state_d = RD_RESP;
        end else if (cnt_d == CNT_W'(RD_TIMEOUT)) begin
          rdata_d = AXI_DATA_WIDTH'(32'hDEAD_BEEF);
          rresp_d = RESP_SLVERR;
          state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        if (rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign awready = wr_accept_c;
  assign wready  = wr_accept_c;
  assign arready = rd_accept_c;

  assign bvalid = (state_q == WR_RESP);
  assign bresp  = bresp_q;
  assign rvalid = (state_q == RD_RESP);
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;

  // Strobes decode from distinct states, so they are mutually exclusive.
  assign cfg_wr_en   = (state_q == WR_ISSUE);
  assign cfg_wr_addr = cfg_wr_en ? addr_q : '0;
  assign cfg_wr_data = cfg_wr_en ? wdata_q : '0;
  assign cfg_rd_en   = (state_q == RD_ISSUE);
  assign cfg_rd_addr = cfg_rd_en ? addr_q : '0;

  assign cfg_wr_clk_en = 1'b1;
  assign cfg_rd_clk_en = 1'b1;

endmodule
